// File: rtl/clock_mode_fsm.sv
// clock_mode_fsm: system mode / tune-field controller for the clock.
// Turns debounced key pulses and the alarm-match pulse into registered
// mode and tune codes, and issues one-cycle field-adjust strobes to the
// time and alarm counters.
module clock_mode_fsm #(
  parameter logic [31:0] INIT_CYCLES    = 32'd50_000_000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
  parameter logic [31:0] ALARM_CYCLES   = 32'd1_500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode_p,
  input  logic       key_sel_p,
  input  logic       key_adj_p,
  input  logic       alarm_hit_p,
  output logic [2:0] sys_status,
  output logic [1:0] tune_status,
  output logic       adj_p,
  output logic [1:0] adj_field,
  output logic       adj_alarm
);

  typedef enum logic [2:0] {
    S_INIT        = 3'd0,
    S_NORM        = 3'd1,
    S_TUNESEL     = 3'd2,
    S_TUNING      = 3'd3,
    S_TUNEALARM   = 3'd4,
    S_ALARMTUNING = 3'd5,
    S_ALARMING    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    T_NONE   = 2'd0,
    T_SECOND = 2'd1,
    T_MINUTE = 2'd2,
    T_HOUR   = 2'd3
  } tune_t;

  state_t      state, next_state;
  tune_t       tune, next_tune;
  logic [31:0] cnt;
  logic        key_accepted;
  logic        next_adj_p;
  logic [1:0]  next_adj_field;
  logic        next_adj_alarm;
  logic        tune_timeout;

  // Select key walks SECOND -> MINUTE -> HOUR -> SECOND.
  function automatic tune_t rotate_field(input tune_t cur);
    case (cur)
      T_SECOND: rotate_field = T_MINUTE;
      T_MINUTE: rotate_field = T_HOUR;
      default:  rotate_field = T_SECOND;
    endcase
  endfunction

  assign tune_timeout = (cnt == TIMEOUT_CYCLES - 32'd1);

  // Next-state, next-tune and adjust-strobe decode; key priority is mode > sel > adj.
  always_comb begin
    next_state     = state;
    next_tune      = tune;
    key_accepted   = 1'b0;
    next_adj_p     = 1'b0;
    next_adj_field = 2'd0;
    next_adj_alarm = 1'b0;
    case (state)
      S_INIT: begin
        if (cnt == INIT_CYCLES - 32'd1) next_state = S_NORM;
      end
      S_NORM: begin
        if (alarm_hit_p) begin
          next_state = S_ALARMING;
        end else if (key_mode_p) begin
          next_state   = S_TUNESEL;
          next_tune    = T_SECOND;
          key_accepted = 1'b1;
        end
      end
      S_TUNESEL, S_TUNEALARM: begin
        if (key_mode_p) begin
          key_accepted = 1'b1;
          if (state == S_TUNESEL) begin
            next_state = S_TUNEALARM;
            next_tune  = T_SECOND;
          end else begin
            next_state = S_NORM;
          end
        end else if (key_sel_p) begin
          key_accepted = 1'b1;
          next_tune    = rotate_field(tune);
        end else if (key_adj_p) begin
          key_accepted = 1'b1;
          next_state   = (state == S_TUNESEL) ? S_TUNING : S_ALARMTUNING;
        end else if (tune_timeout) begin
          next_state = S_NORM;
        end
      end
      S_TUNING, S_ALARMTUNING: begin
        if (key_mode_p) begin
          key_accepted = 1'b1;
          next_state   = S_NORM;
        end else if (key_sel_p) begin
          key_accepted = 1'b1;
          next_state   = (state == S_TUNING) ? S_TUNESEL : S_TUNEALARM;
        end else if (key_adj_p) begin
          key_accepted   = 1'b1;
          next_adj_p     = 1'b1;
          next_adj_field = tune;
          next_adj_alarm = (state == S_ALARMTUNING);
        end else if (tune_timeout) begin
          next_state = S_NORM;
        end
      end
      S_ALARMING: begin
        if (key_mode_p || key_sel_p || key_adj_p) begin
          key_accepted = 1'b1;
          next_state   = S_NORM;
        end else if (cnt == ALARM_CYCLES - 32'd1) begin
          next_state = S_NORM;
        end
      end
      default: begin
        next_state = S_NORM;
      end
    endcase
    if (next_state inside {S_INIT, S_NORM, S_ALARMING}) next_tune = T_NONE;
  end

  // State, tune and adjust-strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      tune      <= T_NONE;
      adj_p     <= 1'b0;
      adj_field <= 2'd0;
      adj_alarm <= 1'b0;
    end else begin
      state     <= next_state;
      tune      <= next_tune;
      adj_p     <= next_adj_p;
      adj_field <= next_adj_field;
      adj_alarm <= next_adj_alarm;
    end
  end

  // Shared cycle counter: restarts on any state change or accepted key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 32'd0;
    end else if ((next_state != state) || key_accepted) begin
      cnt <= 32'd0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  assign sys_status  = state;
  assign tune_status = tune;

endmodule
